timer_controller: RTL and testbench
===================================

Name: timer_controller

Overview:
- Countdown-timer sequencer for the digital timer.
- Consumes the one-cycle tick enable derived from the 50 MHz divider.
- Holds the mm:ss count and runs the run/pause/expire state machine from user button pulses.
- Drives the display datapath (min/sec) and the alarm output. All logic is in the clk_50MHz domain; no derived clocks are used.

Parameters:
- TICKS_PER_SEC, 2: tick pulses per one-second decrement; legal range 1..16.
- MAX_MIN, 99: largest loadable minute value.
- ALARM_TICKS, 10: number of tick pulses alarm stays high after expiry; legal range 1..255.

Ports:
- clk_50MHz  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- tick  input  1  one-cycle enable pulse, nominal 2 Hz, synchronous to clk_50MHz.
- btn_start  input  1  one-cycle pulse (already debounced); toggles run/pause.
- btn_clear  input  1  one-cycle pulse; aborts and zeroes the timer.
- load  input  1  one-cycle pulse; captures load_min/load_sec.
- load_min  input  7  minutes preset.
- load_sec  input  6  seconds preset.
- min  output  7  current minutes.
- sec  output  6  current seconds.
- running  output  1  high in RUN state.
- alarm  output  1  high in EXPIRED state.
- state  output  2  IDLE=0, RUN=1, PAUSE=2, EXPIRED=3.

Behaviour:
- Reset (asynchronous, any time including mid-count):
  - state=IDLE; min=0, sec=0; running=0; alarm=0.
  - Internal sub-tick counter sub=0; alarm counter=0.
- All outputs are registered and change on the clk_50MHz edge where the triggering input is sampled high, visible the next cycle.
- Same-cycle priority: btn_clear > load > btn_start > tick.
- btn_clear, in any state: go to IDLE; min=0, sec=0, sub=0, alarm=0.
- load:
  - Accepted only in IDLE or PAUSE; ignored in RUN and EXPIRED.
  - Clamp: min=min(load_min,MAX_MIN), sec=min(load_sec,59). Values 60..63 load as 59.
  - Sets sub=0. State is unchanged.
- btn_start:
  - IDLE → RUN if {min,sec}≠0; ignored if 00:00.
  - RUN → PAUSE.
  - PAUSE → RUN.
  - Ignored in EXPIRED.
- Counting (RUN state, on tick):
  - If sub<TICKS_PER_SEC-1: sub+1.
  - Otherwise sub=0 and the count decrements: if sec>0, sec-1; else sec=59 and min-1.
  - If the decrement produces 00:00, the same edge sets state=EXPIRED and alarm counter=0.
  - min never underflows. RUN with 00:00 is unreachable.
- PAUSE: sub, min and sec hold. The next tick after resume continues the partial second.
- EXPIRED:
  - alarm=1, min=0, sec=0.
  - Each tick increments the alarm counter. On the tick where the counter reaches ALARM_TICKS-1, go to IDLE with alarm=0 on the same edge. Total alarm duration is exactly ALARM_TICKS ticks.
- A tick in IDLE or PAUSE has no effect.
- When a tick and btn_start arrive in the same cycle in RUN: state goes to PAUSE and the tick is dropped.
- When a tick and btn_start arrive in the same cycle in PAUSE: state goes to RUN and the tick is dropped.
- running = (state==RUN), registered alongside state.

Test Plan:
- Reset check: assert reset mid-RUN at 01:30 → min=0, sec=0, state=0, running=0, alarm=0 immediately (asynchronous), held through deassertion.
- Basic countdown: load 0:03, btn_start, 6 ticks (TICKS_PER_SEC=2) → sec 3→2→1→0 on ticks 2, 4, 6; EXPIRED after tick 6; alarm=1 for exactly 10 ticks; then IDLE with alarm=0.
- Minute borrow and clamp: load min=1, sec=63 → displays 01:59. Run 2×119 ticks → reads 00:00 with EXPIRED. Separately, load 1:00 then 2 ticks → 00:59.
- Pause mid-second: load 0:05, start, 1 tick, btn_start (PAUSE), 20 ticks → 00:05 held; btn_start, 1 tick → 00:04.
- Priority and ignore rules: load+btn_clear same cycle → 00:00 IDLE. btn_start at 00:00 → stays IDLE. load during RUN → ignored. tick+btn_start same cycle in RUN → PAUSE with count unchanged.
- Clear during alarm: in EXPIRED at alarm tick 3, btn_clear → IDLE, alarm=0 next cycle; a subsequent start at 00:00 is ignored.

Source files
------------

// File: rtl/timer_controller.sv
// rtl/timer_controller.sv - mm:ss countdown sequencer with run/pause/expire control and timed alarm
module timer_controller #(
  parameter int TICKS_PER_SEC = 2,
  parameter int MAX_MIN       = 99,
  parameter int ALARM_TICKS   = 10
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       load,
  input  logic [6:0] load_min,
  input  logic [5:0] load_sec,
  output logic [6:0] min,
  output logic [5:0] sec,
  output logic       running,
  output logic       alarm,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [3:0] SUB_LAST   = 4'(TICKS_PER_SEC - 1);
  localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);
  localparam logic [6:0] MAX_MIN_V  = 7'(MAX_MIN);
  localparam logic [5:0] SEC_MAX    = 6'd59;

  state_t     state_q, state_d;
  logic [6:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic [3:0] sub_q, sub_d;
  logic [7:0] acnt_q, acnt_d;
  logic       running_q, alarm_q;

  logic       load_ok;
  logic       count_zero;
  logic       sec_end;
  logic       last_sec;
  logic       alarm_done;
  logic [6:0] clamp_min;
  logic [5:0] clamp_sec;

  assign load_ok    = load && (state_q == IDLE || state_q == PAUSE);
  assign count_zero = (min_q == 7'd0) && (sec_q == 6'd0);
  assign sec_end    = (sub_q == SUB_LAST);
  assign last_sec   = (min_q == 7'd0) && (sec_q == 6'd1);
  assign alarm_done = (acnt_q == ALARM_LAST);
  assign clamp_min  = (load_min > MAX_MIN_V) ? MAX_MIN_V : load_min;
  assign clamp_sec  = (load_sec > SEC_MAX) ? SEC_MAX : load_sec;

  // State register plus the registered copies of running/alarm so they track state exactly.
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      min_q     <= 7'd0;
      sec_q     <= 6'd0;
      sub_q     <= 4'd0;
      acnt_q    <= 8'd0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      sub_q     <= sub_d;
      acnt_q    <= acnt_d;
      running_q <= (state_d == RUN);
      alarm_q   <= (state_d == EXPIRED);
    end
  end

  // Priority: clear > accepted load > start > tick; a start always swallows a coincident tick.
  always_comb begin
    state_d = state_q;
    if (btn_clear) begin
      state_d = IDLE;
    end else if (load_ok) begin
      state_d = state_q;
    end else if (btn_start) begin
      case (state_q)
        IDLE:    state_d = count_zero ? IDLE : RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = state_q;
      endcase
    end else if (tick) begin
      case (state_q)
        RUN:     state_d = (sec_end && last_sec) ? EXPIRED : RUN;
        EXPIRED: state_d = alarm_done ? IDLE : EXPIRED;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    min_d  = min_q;
    sec_d  = sec_q;
    sub_d  = sub_q;
    acnt_d = acnt_q;
    if (btn_clear) begin
      min_d  = 7'd0;
      sec_d  = 6'd0;
      sub_d  = 4'd0;
      acnt_d = 8'd0;
    end else if (load_ok) begin
      min_d = clamp_min;
      sec_d = clamp_sec;
      sub_d = 4'd0;
    end else if (btn_start) begin
      sub_d = sub_q;
    end else if (tick) begin
      if (state_q == RUN) begin
        if (!sec_end) begin
          sub_d = sub_q + 4'd1;
        end else begin
          sub_d = 4'd0;
          if (sec_q != 6'd0) begin
            sec_d = sec_q - 6'd1;
          end else begin
            sec_d = SEC_MAX;
            min_d = min_q - 7'd1;
          end
          if (last_sec) begin
            acnt_d = 8'd0;
          end
        end
      end else if (state_q == EXPIRED) begin
        acnt_d = alarm_done ? 8'd0 : acnt_q + 8'd1;
      end
    end
  end

  assign min     = min_q;
  assign sec     = sec_q;
  assign running = running_q;
  assign alarm   = alarm_q;
  assign state   = state_q;

endmodule

// File: tb/tb_timer_controller.sv
// tb/tb_timer_controller.sv - directed and randomized checks of timer_controller against a remaining-seconds model
module tb_timer_controller;

  localparam int TPS  = 2;
  localparam int AT   = 10;
  localparam int MAXM = 99;

  logic       clk_50MHz = 1'b0;
  logic       reset;
  logic       tick, btn_start, btn_clear, load;
  logic [6:0] load_min;
  logic [5:0] load_sec;
  logic [6:0] min;
  logic [5:0] sec;
  logic       running, alarm;
  logic [1:0] state;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: state code, total remaining seconds, ticks into the current second, alarm ticks seen.
  int m_state, m_rem, m_sub, m_acnt;

  timer_controller #(.TICKS_PER_SEC(TPS), .MAX_MIN(MAXM), .ALARM_TICKS(AT)) dut (
    .clk_50MHz(clk_50MHz),
    .reset(reset),
    .tick(tick),
    .btn_start(btn_start),
    .btn_clear(btn_clear),
    .load(load),
    .load_min(load_min),
    .load_sec(load_sec),
    .min(min),
    .sec(sec),
    .running(running),
    .alarm(alarm),
    .state(state)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".min"}, 32'(min), 32'(m_rem / 60));
    chk({tag, ".sec"}, 32'(sec), 32'(m_rem % 60));
    chk({tag, ".state"}, 32'(state), 32'(m_state));
    chk({tag, ".running"}, 32'(running), 32'(m_state == 1));
    chk({tag, ".alarm"}, 32'(alarm), 32'(m_state == 3));
  endtask

  task automatic model_reset();
    m_state = 0;
    m_rem   = 0;
    m_sub   = 0;
    m_acnt  = 0;
  endtask

  task automatic model_step(input bit t, input bit bs, input bit bc, input bit ld, input int lm, input int ls);
    if (bc) begin
      model_reset();
    end else if (ld && (m_state == 0 || m_state == 2)) begin
      m_rem = ((lm > MAXM) ? MAXM : lm) * 60 + ((ls > 59) ? 59 : ls);
      m_sub = 0;
    end else if (bs) begin
      if (m_state == 0 && m_rem != 0) m_state = 1;
      else if (m_state == 1)          m_state = 2;
      else if (m_state == 2)          m_state = 1;
    end else if (t) begin
      if (m_state == 1) begin
        if (m_sub < TPS - 1) begin
          m_sub++;
        end else begin
          m_sub = 0;
          m_rem--;
          if (m_rem == 0) begin
            m_state = 3;
            m_acnt  = 0;
          end
        end
      end else if (m_state == 3) begin
        m_acnt++;
        if (m_acnt == AT) begin
          m_state = 0;
          m_acnt  = 0;
        end
      end
    end
  endtask

  // Drive inputs for one cycle from the falling edge, advance the model at the rising edge, check at the next falling edge.
  task automatic step(input string tag, input bit t, input bit bs, input bit bc, input bit ld, input int lm, input int ls);
    tick      = t;
    btn_start = bs;
    btn_clear = bc;
    load      = ld;
    load_min  = 7'(lm);
    load_sec  = 6'(ls);
    @(posedge clk_50MHz);
    model_step(t, bs, bc, ld, lm, ls);
    @(negedge clk_50MHz);
    tick      = 1'b0;
    btn_start = 1'b0;
    btn_clear = 1'b0;
    load      = 1'b0;
    check_all(tag);
  endtask

  task automatic do_tick(input string tag);  step(tag, 1, 0, 0, 0, 0, 0); endtask
  task automatic do_start(input string tag); step(tag, 0, 1, 0, 0, 0, 0); endtask
  task automatic do_clear(input string tag); step(tag, 0, 0, 1, 0, 0, 0); endtask
  task automatic do_load(input string tag, input int lm, input int ls); step(tag, 0, 0, 0, 1, lm, ls); endtask

  initial begin
    reset = 1'b1;
    tick = 1'b0; btn_start = 1'b0; btn_clear = 1'b0; load = 1'b0;
    load_min = 7'd0; load_sec = 6'd0;
    model_reset();
    repeat (2) @(negedge clk_50MHz);
    check_all("reset_hold");
    reset = 1'b0;
    @(negedge clk_50MHz);
    check_all("after_reset");

    // Basic countdown 0:03 then a full alarm period
    do_load("bc_load", 0, 3);
    do_start("bc_start");
    for (int i = 0; i < 6; i++) begin
      do_tick("bc_tick");
      step("bc_gap", 0, 0, 0, 0, 0, 0);
    end
    chk("bc_expired_state", 32'(state), 32'd3);
    chk("bc_expired_alarm", 32'(alarm), 32'd1);
    for (int i = 0; i < AT - 1; i++) begin
      do_tick("bc_alarm_tick");
      chk("bc_alarm_held", 32'(alarm), 32'd1);
    end
    do_tick("bc_alarm_last");
    chk("bc_alarm_end_state", 32'(state), 32'd0);
    chk("bc_alarm_end_alarm", 32'(alarm), 32'd0);

    // Asynchronous reset in the middle of a running count
    do_load("rst_load", 1, 30);
    do_start("rst_start");
    do_tick("rst_tick");
    chk("rst_pre_min", 32'(min), 32'd1);
    chk("rst_pre_sec", 32'(sec), 32'd30);
    #3 reset = 1'b1;
    #2;
    chk("rst_async_min", 32'(min), 32'd0);
    chk("rst_async_sec", 32'(sec), 32'd0);
    chk("rst_async_state", 32'(state), 32'd0);
    chk("rst_async_running", 32'(running), 32'd0);
    chk("rst_async_alarm", 32'(alarm), 32'd0);
    model_reset();
    @(negedge clk_50MHz);
    reset = 1'b0;
    step("rst_release", 0, 0, 0, 0, 0, 0);

    // Clamp and minute borrow
    do_load("clamp_load", 1, 63);
    chk("clamp_min", 32'(min), 32'd1);
    chk("clamp_sec", 32'(sec), 32'd59);
    do_load("clamp_load_hi", 120, 61);
    chk("clamp_hi_min", 32'(min), 32'd99);
    do_load("borrow_load", 1, 63);
    do_start("borrow_start");
    for (int i = 0; i < 2 * 119; i++) do_tick("borrow_tick");
    chk("borrow_end_state", 32'(state), 32'd3);
    chk("borrow_end_min", 32'(min), 32'd0);
    chk("borrow_end_sec", 32'(sec), 32'd0);
    do_clear("borrow_clear");
    do_load("b100_load", 1, 0);
    do_start("b100_start");
    do_tick("b100_tick1");
    do_tick("b100_tick2");
    chk("b100_min", 32'(min), 32'd0);
    chk("b100_sec", 32'(sec), 32'd59);
    do_clear("b100_clear");

    // Pause in the middle of a second
    do_load("pause_load", 0, 5);
    do_start("pause_start");
    do_tick("pause_tick");
    do_start("pause_pause");
    for (int i = 0; i < 20; i++) do_tick("pause_held_tick");
    chk("pause_held_sec", 32'(sec), 32'd5);
    chk("pause_held_state", 32'(state), 32'd2);
    do_start("pause_resume");
    do_tick("pause_resume_tick");
    chk("pause_resume_sec", 32'(sec), 32'd4);
    do_clear("pause_clear");

    // Priority and ignore rules
    step("prio_load_clear", 0, 0, 1, 1, 5, 5);
    chk("prio_lc_sec", 32'(sec), 32'd0);
    do_start("prio_start_zero");
    chk("prio_start_zero_state", 32'(state), 32'd0);
    do_load("prio_load", 0, 10);
    do_start("prio_start");
    do_load("prio_load_in_run", 0, 30);
    chk("prio_load_in_run_sec", 32'(sec), 32'd10);
    step("prio_tick_start", 1, 1, 0, 0, 0, 0);
    chk("prio_tick_start_state", 32'(state), 32'd2);
    chk("prio_tick_start_sec", 32'(sec), 32'd10);
    do_clear("prio_clear");

    // Clear during alarm
    do_load("ca_load", 0, 1);
    do_start("ca_start");
    do_tick("ca_tick1");
    do_tick("ca_tick2");
    for (int i = 0; i < 3; i++) do_tick("ca_alarm_tick");
    do_clear("ca_clear");
    chk("ca_clear_state", 32'(state), 32'd0);
    chk("ca_clear_alarm", 32'(alarm), 32'd0);
    do_start("ca_start_zero");
    chk("ca_start_zero_state", 32'(state), 32'd0);

    // Randomized traffic, biased toward short presets so expiry is reached often
    for (int i = 0; i < 4000; i++) begin
      int r, lm, ls;
      bit bc, ld, bs, t;
      r  = int'($urandom % 100);
      bc = (r < 2);
      ld = (r >= 2 && r < 7);
      bs = (r >= 7 && r < 12);
      t  = ($urandom % 3 == 0);
      lm = ($urandom % 8 == 0) ? int'($urandom % 128) : int'($urandom % 2);
      ls = int'($urandom % 64);
      step("rand", t, bs, bc, ld, lm, ls);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
